log2_iter: RTL
==============

LOG2_ITER -- requirements
Module: log2_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be >= 2.
REQ-002 Parameter STEP, default 4: bits scanned per cycle; SHALL be a power of two, SHALL divide WIDTH, SHALL be <= WIDTH.
REQ-003 Derived constant RW = $clog2(WIDTH+1): result width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand offered.
REQ-007 in_ready  out  1  block accepts an operand.
REQ-008 in_n  in  WIDTH  operand N.
REQ-009 in_mode  in  2  mode: 00 FLOOR, 01 CEIL, 10 BITS, 11 illegal.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_result  out  RW  computed value.
REQ-013 out_zero  out  1  captured N was 0.
REQ-014 out_pow2  out  1  captured N had exactly one bit set.
REQ-015 out_err  out  1  captured mode was 11.

Function
REQ-016 Definition: msb = index of the highest set bit of N.
REQ-017 FLOOR mode: N=0 yields result 0; otherwise result is msb.
REQ-018 CEIL mode: N=0 or N=1 yields 0; a power of two yields msb; any other N yields msb+1.
REQ-019 BITS mode: N=0 or N=1 yields 1; otherwise result is msb+1.
REQ-020 Mode 11: result 0 and out_err=1; the operand SHALL still be scanned so out_zero and out_pow2 stay valid.
REQ-021 State machine states: IDLE, SCAN, DONE.
REQ-022 in_ready SHALL be 1 only in IDLE.
REQ-023 Accept occurs when in_valid & in_ready: N and mode are registered; pow2 = (N!=0)&&((N&(N-1))==0) is registered; the window pointer is set to the top STEP bits; next state is SCAN.
REQ-024 SCAN, each cycle: examine one STEP-bit window, starting at the MSB end.
REQ-025 SCAN, window has a set bit: record msb as the highest set bit inside the window, then go to DONE.
REQ-026 SCAN, window all zero: step the pointer down by STEP.
REQ-027 SCAN, lowest window all zero: set zero=1, then go to DONE.
REQ-028 SCAN length is (WIDTH-1-msb)/STEP+1 cycles, or WIDTH/STEP cycles for N=0.
REQ-029 Accept-to-out_valid latency is the SCAN length; out_valid asserts on the cycle the FSM enters DONE.
REQ-030 DONE holds out_valid=1 and all out_* stable until out_valid & out_ready, then moves to IDLE.
REQ-031 No new operand is accepted during the handshake cycle; minimum initiation interval is SCAN length + 2.
REQ-032 out_result, out_zero, out_pow2 and out_err SHALL be registered; no combinational path from in_* to out_*.
REQ-033 In CEIL mode with N=2^(WIDTH-1)+1 the result is WIDTH, which fits in RW bits; no truncation anywhere.
REQ-034 in_n and in_mode are ignored when not accepted.
REQ-035 out_ready is ignored outside DONE.

Reset
REQ-036 While rst_n=0: state is IDLE; in_ready=1; out_valid=0; out_result=0; out_zero=0; out_pow2=0; out_err=0; internal registers are cleared.
REQ-037 Reset asserted during SCAN or DONE abandons the operation; no out_valid follows.
REQ-038 After rst_n deasserts, the first rising edge may accept an operand.

Structure
REQ-039 A shared package SHALL hold: mode encodings LOG2_FLOOR/LOG2_CEIL/LOG2_BITS/LOG2_ILLEGAL, state encodings, and the RW derivation function.
REQ-040 One sub-module, log2_window_pe, SHALL be used: a STEP-bit priority encoder outputting a hit flag and the in-window index.
REQ-041 log2_iter SHALL hold the FSM, pointer and registers.

Verification (WIDTH=32, STEP=4)
REQ-042 FLOOR, N=0x8000_0000 -> result 31, pow2=1, out_valid 1 cycle after accept.
REQ-043 FLOOR, N=1 -> result 0, pow2=1, latency 8 cycles; FLOOR, N=0 -> result 0, zero=1, latency 8 cycles.
REQ-044 CEIL: N=5 -> 3; N=4 -> 2; N=0x8000_0001 -> 32. BITS: N=0 -> 1 with zero=1; N=1 -> 1; N=255 -> 8.
REQ-045 Mode 11, N=6 -> result 0, err=1, pow2=0; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-046 rst_n pulsed low mid-SCAN for N=0x10 -> all outputs return to reset values immediately, no out_valid; the next operand completes correctly.
REQ-047 Random N and mode, 10k transactions with random valid/ready gaps -> every result matches the reference model; no lost or duplicated results.

Source files
------------

// File: rtl/log2_iter_pkg.sv
// Shared encodings and width helpers for the iterative log2 unit.
// Imported by the interface, the window encoder and the top.
package log2_iter_pkg;

   typedef enum logic [1:0] {
      LOG2_FLOOR   = 2'b00,
      LOG2_CEIL    = 2'b01,
      LOG2_BITS    = 2'b10,
      LOG2_ILLEGAL = 2'b11
   } log2_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } log2_state_e;

   // Result must hold WIDTH itself (CEIL of 2^(WIDTH-1)+1), hence WIDTH+1.
   function automatic int log2_rw(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int log2_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/log2_iter_if.sv
// Operand/result handshake bundle for log2_iter.
// The master drives operands and out_ready; the slave returns the result.
interface log2_iter_if #(
   parameter int WIDTH = 32
);
   import log2_iter_pkg::*;

   localparam int RW = log2_rw(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_n;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [RW-1:0]    out_result;
   logic             out_zero;
   logic             out_pow2;
   logic             out_err;

   modport master (
      output in_valid, in_n, in_mode, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_pow2, out_err
   );

   modport slave (
      input  in_valid, in_n, in_mode, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_pow2, out_err
   );

endinterface

// File: rtl/log2_window_pe.sv
// STEP-bit priority encoder: reports whether any bit is set and the
// index of the highest set bit within the window.
module log2_window_pe
   import log2_iter_pkg::*;
#(
   parameter  int STEP = 4,
   localparam int SW   = log2_idx_w(STEP)
) (
   input  logic [STEP-1:0] win_i,
   output logic            hit_o,
   output logic [SW-1:0]   idx_o
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      hit_o = 1'b0;
      idx_o = {SW{1'b0}};
      for (int i = 0; i < STEP; i++) begin
         if (win_i[i]) begin
            hit_o = 1'b1;
            idx_o = SW'(i);
         end else begin
            hit_o = hit_o;
            idx_o = idx_o;
         end
      end
   end

endmodule

// File: rtl/log2_iter.sv
// Iterative floor/ceil log2 and bit-length unit: scans the operand STEP
// bits per cycle from the MSB end and presents a registered result.
module log2_iter
   import log2_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input logic       clk,
   input logic       rst_n,
   log2_iter_if.slave bus
);

   localparam int RW = log2_rw(WIDTH);
   localparam int NW = WIDTH / STEP;
   localparam int PW = log2_idx_w(NW);
   localparam int SW = log2_idx_w(STEP);

   log2_state_e      state_q;
   logic [WIDTH-1:0] n_q;
   log2_mode_e       mode_q;
   logic             pow2_q;
   logic [PW-1:0]    ptr_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [RW-1:0]    out_result_q;
   logic             out_zero_q;
   logic             out_pow2_q;
   logic             out_err_q;

   logic [STEP-1:0]  win_s;
   logic             hit_s;
   logic [SW-1:0]    idx_s;
   logic [RW-1:0]    msb_s;
   logic             pow2_s;
   logic             zero_d;
   logic [RW-1:0]    result_d;

   assign pow2_s = (bus.in_n != {WIDTH{1'b0}}) &&
                   ((bus.in_n & (bus.in_n - WIDTH'(1))) == {WIDTH{1'b0}});
   assign win_s  = n_q[int'(ptr_q) * STEP +: STEP];

   log2_window_pe #(.STEP(STEP)) u_pe (
      .win_i (win_s),
      .hit_o (hit_s),
      .idx_o (idx_s)
   );

   // Result for the current window, used only on the cycle SCAN ends.
   always_comb begin
      zero_d = ~hit_s;
      msb_s  = RW'(ptr_q) * RW'(STEP) + RW'(idx_s);
      case (mode_q)
         LOG2_FLOOR: result_d = zero_d ? {RW{1'b0}} : msb_s;
         LOG2_CEIL:  result_d = zero_d ? {RW{1'b0}} : (pow2_q ? msb_s : msb_s + RW'(1));
         LOG2_BITS:  result_d = zero_d ? RW'(1) : msb_s + RW'(1);
         default:    result_d = {RW{1'b0}};
      endcase
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         n_q          <= {WIDTH{1'b0}};
         mode_q       <= LOG2_FLOOR;
         pow2_q       <= 1'b0;
         ptr_q        <= {PW{1'b0}};
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_result_q <= {RW{1'b0}};
         out_zero_q   <= 1'b0;
         out_pow2_q   <= 1'b0;
         out_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  n_q        <= bus.in_n;
                  mode_q     <= log2_mode_e'(bus.in_mode);
                  pow2_q     <= pow2_s;
                  ptr_q      <= PW'(NW - 1);
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // A hit, or running out of windows, both finish the scan.
               if (hit_s || (ptr_q == {PW{1'b0}})) begin
                  out_result_q <= result_d;
                  out_zero_q   <= zero_d;
                  out_pow2_q   <= pow2_q;
                  out_err_q    <= (mode_q == LOG2_ILLEGAL);
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_DONE;
               end else begin
                  ptr_q <= ptr_q - PW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_zero   = out_zero_q;
   assign bus.out_pow2   = out_pow2_q;
   assign bus.out_err    = out_err_q;

endmodule
